array_ram: RTL and testbench

ARRAY_RAM -- requirements
Module: array_ram

---
 rtl/array_ram.sv | 76 +++++++
 tb/tb_array_ram.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/array_ram.sv
// array_ram: single-port word RAM with a registered response and one-cycle
// latency. Macro ARRAY_RAM_CLEAR_EN selects a resettable (cleared) array.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   nrst  - asynchronous active-low reset
//   addr  - word address of the current request
//   we    - 1 = write, 0 = read (sampled while valid=1)
//   di    - write data (sampled while valid=1 and we=1)
//   valid - request strobe, one request per cycle while high
//   dout  - registered response data (read data or write echo)
//   ready - response strobe, high one cycle after each request
module array_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] di,
  input  logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr;
  logic              rd;

  assign wr = valid & we;
  assign rd = valid & ~we;

`ifdef ARRAY_RAM_CLEAR_EN
  // Flop-based array: reset wipes every word so early reads return 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[addr] <= di;
    end
  end
`else
  // RAM-inferable array; gating on nrst blocks writes during reset.
  always_ff @(posedge clk) begin
    if (wr && nrst) begin
      mem[addr] <= di;
    end
  end
`endif

  // Read returns the pre-edge word; a write echoes its own data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout <= '0;
    end else if (wr) begin
      dout <= di;
    end else if (rd) begin
      dout <= mem[addr];
    end
  end

  // Reset clears ready, so any request in flight is dropped.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ready <= 1'b0;
    end else begin
      ready <= valid;
    end
  end

endmodule

// File: tb/tb_array_ram.sv
// tb_array_ram: table-driven vectors plus hand-written reset, streaming
// and clear sequences for array_ram.
module tb_array_ram;

  logic       clk;
  logic       nrst;
  logic [7:0] addr;
  logic       we;
  logic [7:0] di;
  logic       valid;
  logic [7:0] dout;
  logic       ready;

  int checks;
  int errors;

  array_ram #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .addr  (addr),
    .we    (we),
    .di    (di),
    .valid (valid),
    .dout  (dout),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       we;
    logic [7:0] addr;
    logic [7:0] di;
    logic       ready;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic req(input logic v, input logic w,
                     input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    valid = v;
    we    = w;
    addr  = a;
    di    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    valid  = 1'b0;
    we     = 1'b0;
    addr   = '0;
    di     = '0;
    nrst   = 1'b0;

    //            v  we addr   di     rdy dout
    vecs[0]  = '{1, 1, 8'd3,   8'h21, 1, 8'h21};
    vecs[1]  = '{1, 0, 8'd3,   8'h00, 1, 8'h21};
    vecs[2]  = '{1, 1, 8'd7,   8'h07, 1, 8'h07};
    vecs[3]  = '{1, 0, 8'd3,   8'h00, 1, 8'h21};
    vecs[4]  = '{1, 0, 8'd7,   8'h00, 1, 8'h07};
    vecs[5]  = '{0, 1, 8'd7,   8'h55, 0, 8'h07};
    vecs[6]  = '{0, 0, 8'd3,   8'h00, 0, 8'h07};
    vecs[7]  = '{1, 0, 8'd7,   8'h00, 1, 8'h07};
    vecs[8]  = '{1, 1, 8'd255, 8'hFF, 1, 8'hFF};
    vecs[9]  = '{1, 1, 8'd0,   8'h01, 1, 8'h01};
    vecs[10] = '{1, 0, 8'd255, 8'h00, 1, 8'hFF};
    vecs[11] = '{1, 0, 8'd0,   8'h00, 1, 8'h01};

    #12;
    chk("rst_ready", {7'd0, ready}, 8'd0);
    chk("rst_do", dout, 8'h00);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      req(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].di);
      chk($sformatf("vec%0d_ready", i), {7'd0, ready},
          {7'd0, vecs[i].ready});
      chk($sformatf("vec%0d_do", i), dout, vecs[i].dout);
    end

    // streaming writes then reads, valid never drops
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b1, 8'(i), 8'(i));
      chk($sformatf("sw%0d_ready", i), {7'd0, ready}, 8'd1);
      chk($sformatf("sw%0d_do", i), dout, 8'(i));
    end
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b0, 8'(i), 8'h00);
      chk($sformatf("sr%0d_ready", i), {7'd0, ready}, 8'd1);
      chk($sformatf("sr%0d_do", i), dout, 8'(i));
    end

    // async reset mid-run with do=0x5A
    req(1'b1, 1'b1, 8'd5, 8'h5A);
    chk("pre_rst_do", dout, 8'h5A);
    chk("pre_rst_ready", {7'd0, ready}, 8'd1);
    valid = 1'b1;
    we    = 1'b1;
    addr  = 8'd5;
    di    = 8'h99;
    #1;
    nrst = 1'b0;
    #1;
    chk("async_rst_ready", {7'd0, ready}, 8'd0);
    chk("async_rst_do", dout, 8'h00);
    // write held across an edge in reset must be dropped
    @(posedge clk);
    #1;
    chk("in_rst_ready", {7'd0, ready}, 8'd0);
    @(negedge clk);
    valid = 1'b0;
    nrst  = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {7'd0, ready}, 8'd0);
    // first request accepted at first edge after release
    req(1'b1, 1'b0, 8'd5, 8'h00);
    chk("first_req_ready", {7'd0, ready}, 8'd1);
`ifdef ARRAY_RAM_CLEAR_EN
    chk("rst_write_blocked", dout, 8'h00);
`else
    chk("rst_write_blocked", dout, 8'h5A);
`endif
    req(1'b1, 1'b0, 8'd15, 8'h00);
`ifdef ARRAY_RAM_CLEAR_EN
    chk("rst_keep15", dout, 8'h00);
    req(1'b1, 1'b1, 8'd9, 8'h33);
    chk("clr_wr_do", dout, 8'h33);
    @(negedge clk);
    valid = 1'b0;
    nrst  = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    req(1'b1, 1'b0, 8'd9, 8'h00);
    chk("clr_ready", {7'd0, ready}, 8'd1);
    chk("clr_do", dout, 8'h00);
`else
    chk("rst_keep15", dout, 8'd15);
`endif

    req(1'b0, 1'b0, 8'd0, 8'h00);
    chk("end_idle_ready", {7'd0, ready}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
